manual_drive_ctrl: RTL and testbench
====================================

Name: manual_drive_ctrl

Overview:
- Parametrised next-generation driving-mode controller for the simulated car.
- Folds the power-on hold timer, the reverse-change detector and a tick divider into one block, and adds:
  - universal power-off
  - idle auto-power-off
  - turn-LED flashing
  - a saturating trip odometer
- Sits between the debounced switch/button inputs and the UART command byte / LED / seven-segment drivers.

Parameters:
- CLK_FREQ_HZ, 100000000, sys_clk frequency.
- TICK_HZ, 1000, internal tick rate. TICK_DIV = CLK_FREQ_HZ/TICK_HZ must be an integer ≥1.
- POWER_ON_HOLD_TICKS, 1000, number of ticks power_on_signal must be held to power up.
- IDLE_OFF_TICKS, 10000, number of ticks of inactivity in power_on/not_starting before auto power-off.
- FLASH_HALF_TICKS, 250, half-period of the turn-LED flash, in ticks.
- ODO_TICKS_PER_UNIT, 1000, number of moving ticks per odometer increment.
- ODO_W, 16, odometer width.

Ports:
- sys_clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- power_on_signal  in  1  power button
- power_off_signal  in  1  power-off button
- manual_driving_signal  in  1  selects manual mode
- throttle_signal, clutch_signal, brake_signal, reverse_signal  in  1 each  pedals/gear
- turn_left_signal, turn_right_signal, place_barrier_signal, destroy_barrier_signal  in  1 each
- cmd  out  6  {destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward}, registered
- state_led  out  4  current state code
- left_turn_led, right_turn_led, reverse_led  out  1 each
- odometer  out  ODO_W  trip distance units
- tick  out  1  one-cycle pulse every TICK_DIV cycles, for downstream display

Behaviour:
- Inputs are synchronous and debounced upstream.
- Reset (rst=0, asynchronous): state=POWER_OFF. cmd, odometer, all LEDs, all counters, tick and the prev-reverse register are 0.
- Tick: counter runs 0..TICK_DIV-1. tick=1 in the cycle it wraps. TICK_DIV=1 gives tick=1 every cycle.
- State codes (shared pkg): POWER_OFF=0, POWER_ON=1, NOT_STARTING=2, STARTING=3, MOVING=4. Undefined codes go to POWER_OFF.
- Transition priority, highest first. Evaluated every cycle; the state register updates on the next edge.
  1. Any state ≠ POWER_OFF with power_off_signal=1 → POWER_OFF.
  2. POWER_OFF:
     - hold counter increments on tick while power_on_signal=1; clears to 0 when power_on_signal=0.
     - when counter reaches POWER_ON_HOLD_TICKS → POWER_ON, counter cleared.
  3. POWER_ON: manual_driving_signal=1 → NOT_STARTING.
  4. NOT_STARTING, using {throttle, brake, clutch}:
     - 101 → STARTING.
     - 100 (stall) → POWER_OFF.
     - otherwise stay.
  5. STARTING:
     - brake=1 → NOT_STARTING.
     - else 100 → MOVING.
     - otherwise stay.
  6. MOVING:
     - reverse_signal ≠ prev-reverse and clutch=0 → POWER_OFF.
     - else brake=1 → NOT_STARTING.
     - else throttle=0 or clutch=1 → STARTING.
     - otherwise stay.
  7. Idle timer, in POWER_ON and NOT_STARTING only:
     - increments on tick while throttle, clutch, brake, manual_driving_signal, turn_left_signal and turn_right_signal are all 0.
     - clears on any of these =1 or on any state change.
     - reaching IDLE_OFF_TICKS → POWER_OFF. Rules 1–6 win the same cycle.
- prev-reverse register samples reverse_signal every cycle in all states.
- cmd is registered, one cycle behind state:
  - MOVING: {destroy, place, right, left, reverse, ~reverse}.
  - Any other state: 0.
- LEDs (combinational from registered state):
  - state_led = state.
  - NOT_STARTING: both turn LEDs steady 1, reverse_led=0.
  - STARTING: turn LEDs 0, reverse_led = reverse_signal.
  - MOVING: reverse_led = reverse_signal. Each turn LED = its signal AND flash phase.
  - Flash phase:
    - set to 1 on a rising edge of either turn signal.
    - toggles every FLASH_HALF_TICKS ticks while either turn signal is 1.
    - forced to 1 outside MOVING.
  - Other states: all LEDs 0.
- Odometer:
  - sub-counter increments on tick in MOVING.
  - at ODO_TICKS_PER_UNIT the sub-counter wraps and odometer +1.
  - odometer saturates at 2^ODO_W-1; no wrap.
  - odometer and sub-counter clear on entry to POWER_OFF.
  - outside MOVING the sub-counter holds.
- Reset mid-operation returns every output to its reset value within the same cycle (async).

Decomposition:
- Package drive_pkg holds:
  - state localparams
  - the cmd bit-index constants
  - the {throttle, brake, clutch} pattern constants
- One natural sub-module, tick_gen (parameter TICK_DIV; ports sys_clk, rst, tick).
- FSM, timers, flash and odometer stay in manual_drive_ctrl.

Test Plan:
Bench parameters: CLK_FREQ_HZ=TICK_HZ=1, POWER_ON_HOLD_TICKS=4, IDLE_OFF_TICKS=8, FLASH_HALF_TICKS=2, ODO_TICKS_PER_UNIT=3, ODO_W=3.
1. Power-on hold:
   - power_on held 3 cycles then released → state stays 0.
   - held 4 cycles → state_led=1 one cycle after the 4th tick.
2. Start and drive:
   - manual=1, then {t,b,c}=101 → state 3; then 100 → state 4.
   - next cycle cmd=000001.
   - reverse=1 with clutch=1 → cmd=000010, reverse_led=1.
3. Illegal gear change: in MOVING, toggle reverse with clutch=0 → state 0 next cycle, cmd=0 the cycle after.
4. Flash and odometer:
   - in MOVING, turn_left=1 → left_turn_led pattern 1,1,0,0,1,1…
   - after 21 moving cycles odometer=7 and stays 7 (saturation).
5. Idle timeout and stall:
   - NOT_STARTING with all inputs 0 for 8 ticks → state 0.
   - separately {t,b,c}=100 in NOT_STARTING → state 0 and odometer cleared.
6. Async reset: assert rst=0 mid-MOVING between clock edges → cmd=0, state_led=0, odometer=0 immediately.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared definitions for the manual driving-mode controller: state codes,
// command-byte bit positions, pedal patterns and a counter-width helper.
package drive_pkg;

    // Driving-mode state codes, also shown on state_led
    typedef enum logic [2:0] {
        POWER_OFF    = 3'd0,
        POWER_ON     = 3'd1,
        NOT_STARTING = 3'd2,
        STARTING     = 3'd3,
        MOVING       = 3'd4
    } drive_state_e;

    localparam int unsigned STATE_LED_W = 4;
    localparam int unsigned CMD_W       = 6;

    // Bit positions inside the UART command byte
    localparam int unsigned CMD_FWD     = 0;
    localparam int unsigned CMD_BWD     = 1;
    localparam int unsigned CMD_LEFT    = 2;
    localparam int unsigned CMD_RIGHT   = 3;
    localparam int unsigned CMD_PLACE   = 4;
    localparam int unsigned CMD_DESTROY = 5;

    // Pedal patterns, ordered {throttle, brake, clutch}
    localparam logic [2:0] TBC_START = 3'b101;
    localparam logic [2:0] TBC_STALL = 3'b100;
    localparam logic [2:0] TBC_DRIVE = 3'b100;

    // Width of a counter that must be able to hold max_val
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick divider: registered one-cycle pulse every TICK_DIV sys_clk cycles.
// Ports: sys_clk (clock), rst (async active-low reset), tick (pulse out).
module tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             wrap_c;

    assign wrap_c = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Free-running 0..TICK_DIV-1 counter; tick marks the wrap
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= wrap_c;
            cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual driving-mode controller: power-on hold, mode FSM, idle auto-off,
// turn-LED flashing and saturating trip odometer.
// Ports: sys_clk/rst (clock, async active-low reset); power_on/off, manual,
// pedal, gear, turn and barrier inputs; cmd (registered UART command byte),
// state_led/turn/reverse LEDs, odometer, tick (divided tick pulse).
module manual_drive_ctrl
    import drive_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ         = 100000000,
    parameter int unsigned TICK_HZ             = 1000,
    parameter int unsigned POWER_ON_HOLD_TICKS = 1000,
    parameter int unsigned IDLE_OFF_TICKS      = 10000,
    parameter int unsigned FLASH_HALF_TICKS    = 250,
    parameter int unsigned ODO_TICKS_PER_UNIT  = 1000,
    parameter int unsigned ODO_W               = 16
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   power_on_signal,
    input  logic                   power_off_signal,
    input  logic                   manual_driving_signal,
    input  logic                   throttle_signal,
    input  logic                   clutch_signal,
    input  logic                   brake_signal,
    input  logic                   reverse_signal,
    input  logic                   turn_left_signal,
    input  logic                   turn_right_signal,
    input  logic                   place_barrier_signal,
    input  logic                   destroy_barrier_signal,
    output logic [CMD_W-1:0]       cmd,
    output logic [STATE_LED_W-1:0] state_led,
    output logic                   left_turn_led,
    output logic                   right_turn_led,
    output logic                   reverse_led,
    output logic [ODO_W-1:0]       odometer,
    output logic                   tick
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned HOLD_W   = cnt_w(POWER_ON_HOLD_TICKS);
    localparam int unsigned IDLE_W   = cnt_w(IDLE_OFF_TICKS);
    localparam int unsigned FLASH_W  = cnt_w(FLASH_HALF_TICKS);
    localparam int unsigned SUB_W    = cnt_w(ODO_TICKS_PER_UNIT);

    drive_state_e        state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
    logic [IDLE_W-1:0]   idle_q, idle_d, idle_inc;
    logic [FLASH_W-1:0]  flash_cnt_q, flash_inc;
    logic [SUB_W-1:0]    sub_q, sub_inc;
    logic [CMD_W-1:0]    cmd_d;
    logic [2:0]          tbc;
    logic                flash_q, flash_base;
    logic                prev_rev_q, prev_left_q, prev_right_q;
    logic                quiet, turn_any, turn_rise, enter_off;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick    (tick)
    );

    assign tbc       = {throttle_signal, brake_signal, clutch_signal};
    assign quiet     = ~(throttle_signal | clutch_signal | brake_signal |
                         manual_driving_signal | turn_left_signal | turn_right_signal);
    assign turn_any  = turn_left_signal | turn_right_signal;
    assign turn_rise = (turn_left_signal & ~prev_left_q) | (turn_right_signal & ~prev_right_q);
    assign enter_off = (state_d == POWER_OFF) && (state_q != POWER_OFF);

    // State register and power-on / idle timers
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= POWER_OFF;
            hold_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idle_q  <= idle_d;
        end
    end

    // Next state: mode rules first, then power-off override, then idle timeout
    always_comb begin
        state_d  = state_q;
        hold_d   = '0;
        idle_d   = '0;
        hold_inc = hold_q + HOLD_W'(1);
        idle_inc = idle_q + IDLE_W'(1);
        case (state_q)
            POWER_OFF: begin
                if (power_on_signal) begin
                    hold_d = hold_q;
                    if (tick) begin
                        if (hold_inc == HOLD_W'(POWER_ON_HOLD_TICKS)) begin
                            state_d = POWER_ON;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                end
            end
            POWER_ON: begin
                if (manual_driving_signal) state_d = NOT_STARTING;
            end
            NOT_STARTING: begin
                if (tbc == TBC_START)      state_d = STARTING;
                else if (tbc == TBC_STALL) state_d = POWER_OFF;
            end
            STARTING: begin
                if (brake_signal)          state_d = NOT_STARTING;
                else if (tbc == TBC_DRIVE) state_d = MOVING;
            end
            MOVING: begin
                if ((reverse_signal != prev_rev_q) && !clutch_signal) state_d = POWER_OFF;
                else if (brake_signal)                                 state_d = NOT_STARTING;
                else if (!throttle_signal || clutch_signal)            state_d = STARTING;
            end
            default: state_d = POWER_OFF;
        endcase
        if ((state_q != POWER_OFF) && power_off_signal) state_d = POWER_OFF;
        // Idle timer only runs while no rule above moves the state
        if (((state_q == POWER_ON) || (state_q == NOT_STARTING)) && (state_d == state_q) && quiet) begin
            idle_d = idle_q;
            if (tick) begin
                if (idle_inc == IDLE_W'(IDLE_OFF_TICKS)) state_d = POWER_OFF;
                else                                     idle_d  = idle_inc;
            end
        end
    end

    // Command byte and flash-phase helpers
    always_comb begin
        cmd_d      = '0;
        flash_base = turn_rise | flash_q;
        flash_inc  = (turn_rise ? '0 : flash_cnt_q) + FLASH_W'(1);
        sub_inc    = sub_q + SUB_W'(1);
        if (state_q == MOVING) begin
            cmd_d[CMD_FWD]     = ~reverse_signal;
            cmd_d[CMD_BWD]     = reverse_signal;
            cmd_d[CMD_LEFT]    = turn_left_signal;
            cmd_d[CMD_RIGHT]   = turn_right_signal;
            cmd_d[CMD_PLACE]   = place_barrier_signal;
            cmd_d[CMD_DESTROY] = destroy_barrier_signal;
        end
    end

    // Command, edge history, flash phase and odometer
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cmd          <= '0;
            prev_rev_q   <= 1'b0;
            prev_left_q  <= 1'b0;
            prev_right_q <= 1'b0;
            flash_q      <= 1'b1;
            flash_cnt_q  <= '0;
            sub_q        <= '0;
            odometer     <= '0;
        end else begin
            cmd          <= cmd_d;
            prev_rev_q   <= reverse_signal;
            prev_left_q  <= turn_left_signal;
            prev_right_q <= turn_right_signal;

            if (state_q != MOVING) begin
                flash_q     <= 1'b1;
                flash_cnt_q <= '0;
            end else if (turn_any) begin
                // A fresh turn request restarts the phase lit and counts this tick
                if (tick) begin
                    if (flash_inc == FLASH_W'(FLASH_HALF_TICKS)) begin
                        flash_q     <= ~flash_base;
                        flash_cnt_q <= '0;
                    end else begin
                        flash_q     <= flash_base;
                        flash_cnt_q <= flash_inc;
                    end
                end else if (turn_rise) begin
                    flash_q     <= 1'b1;
                    flash_cnt_q <= '0;
                end
            end else begin
                flash_cnt_q <= '0;
            end

            if (enter_off) begin
                sub_q    <= '0;
                odometer <= '0;
            end else if ((state_q == MOVING) && tick) begin
                if (sub_inc == SUB_W'(ODO_TICKS_PER_UNIT)) begin
                    sub_q <= '0;
                    if (odometer != '1) odometer <= odometer + ODO_W'(1);
                end else begin
                    sub_q <= sub_inc;
                end
            end
        end
    end

    // LEDs decoded from the registered state
    always_comb begin
        state_led      = STATE_LED_W'(state_q);
        left_turn_led  = 1'b0;
        right_turn_led = 1'b0;
        reverse_led    = 1'b0;
        case (state_q)
            NOT_STARTING: begin
                left_turn_led  = 1'b1;
                right_turn_led = 1'b1;
            end
            STARTING: reverse_led = reverse_signal;
            MOVING: begin
                reverse_led    = reverse_signal;
                left_turn_led  = turn_left_signal & flash_q;
                right_turn_led = turn_right_signal & flash_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Scoreboard bench for manual_drive_ctrl: a behavioural model queues the
// expected outputs for every cycle, a monitor pops and compares them.
module tb_manual_drive_ctrl;

    localparam int unsigned CLK_FREQ_HZ = 1;
    localparam int unsigned TICK_HZ     = 1;
    localparam int unsigned TICK_DIV    = CLK_FREQ_HZ / TICK_HZ;
    localparam int          HOLD        = 4;
    localparam int          IDLE        = 8;
    localparam int          HALF        = 2;
    localparam int          ODO_T       = 3;
    localparam int unsigned ODO_W       = 3;
    localparam int          ODO_MAX     = (1 << ODO_W) - 1;

    typedef struct packed {
        logic pon, poff, man, thr, clu, brk, rev, tl, tr, plc, dst;
    } stim_t;

    typedef struct packed {
        logic [3:0]       st;
        logic [5:0]       cmd;
        logic             l, r, rv;
        logic [ODO_W-1:0] odo;
        logic             tk;
    } exp_t;

    logic sys_clk, rst;
    logic power_on_signal, power_off_signal, manual_driving_signal;
    logic throttle_signal, clutch_signal, brake_signal, reverse_signal;
    logic turn_left_signal, turn_right_signal, place_barrier_signal, destroy_barrier_signal;
    logic [5:0]       cmd;
    logic [3:0]       state_led;
    logic             left_turn_led, right_turn_led, reverse_led;
    logic [ODO_W-1:0] odometer;
    logic             tick;

    manual_drive_ctrl #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ),
        .POWER_ON_HOLD_TICKS(HOLD), .IDLE_OFF_TICKS(IDLE),
        .FLASH_HALF_TICKS(HALF), .ODO_TICKS_PER_UNIT(ODO_T), .ODO_W(ODO_W)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .power_on_signal(power_on_signal), .power_off_signal(power_off_signal),
        .manual_driving_signal(manual_driving_signal),
        .throttle_signal(throttle_signal), .clutch_signal(clutch_signal),
        .brake_signal(brake_signal), .reverse_signal(reverse_signal),
        .turn_left_signal(turn_left_signal), .turn_right_signal(turn_right_signal),
        .place_barrier_signal(place_barrier_signal), .destroy_barrier_signal(destroy_barrier_signal),
        .cmd(cmd), .state_led(state_led), .left_turn_led(left_turn_led),
        .right_turn_led(right_turn_led), .reverse_led(reverse_led),
        .odometer(odometer), .tick(tick)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    logic rst_v;

    // Reference model state (plain integers)
    int m_state, m_hold, m_idle, m_fcnt, m_sub, m_odo, m_cmd, m_ncyc;
    bit m_phase, m_prev_rev, m_prev_l, m_prev_r;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Mode rules 1-6 as read from the behaviour description
    function automatic int rule_next(input int st, input stim_t s, input bit prev_rev);
        int n;
        n = st;
        case (st)
            1: if (s.man) n = 2;
            2: begin
                if (s.thr && !s.brk && s.clu)       n = 3;
                else if (s.thr && !s.brk && !s.clu) n = 0;
            end
            3: begin
                if (s.brk)                  n = 2;
                else if (s.thr && !s.clu)   n = 4;
            end
            4: begin
                if ((s.rev != prev_rev) && !s.clu) n = 0;
                else if (s.brk)                    n = 2;
                else if (!s.thr || s.clu)          n = 3;
            end
            default: n = 0;
        endcase
        if (st != 0 && s.poff) n = 0;
        return n;
    endfunction

    task automatic model_cycle(input stim_t s, input logic r);
        exp_t e;
        int   nxt;
        bit   tk, quiet;
        e = '0;
        if (!r) begin
            m_state = 0; m_hold = 0; m_idle = 0; m_fcnt = 0; m_sub = 0; m_odo = 0;
            m_cmd = 0; m_ncyc = 0; m_phase = 1'b1;
            m_prev_rev = 1'b0; m_prev_l = 1'b0; m_prev_r = 1'b0;
            q.push_back(e);
            return;
        end
        tk = (m_ncyc >= 1) && ((m_ncyc % TICK_DIV) == 0);
        e.st  = 4'(m_state);
        e.cmd = 6'(m_cmd);
        e.odo = ODO_W'(m_odo);
        e.tk  = tk;
        if (m_state == 2) begin e.l = 1'b1; e.r = 1'b1; end
        if (m_state == 3) e.rv = s.rev;
        if (m_state == 4) begin
            e.rv = s.rev;
            e.l  = s.tl & m_phase;
            e.r  = s.tr & m_phase;
        end
        q.push_back(e);

        nxt = rule_next(m_state, s, m_prev_rev);
        if (m_state == 0 && s.pon) begin
            if (tk) begin
                m_hold++;
                if (m_hold == HOLD) begin nxt = 1; m_hold = 0; end
            end
        end else m_hold = 0;
        quiet = !(s.thr || s.clu || s.brk || s.man || s.tl || s.tr);
        if ((m_state == 1 || m_state == 2) && nxt == m_state && quiet) begin
            if (tk) begin
                m_idle++;
                if (m_idle == IDLE) begin nxt = 0; m_idle = 0; end
            end
        end else m_idle = 0;

        if (nxt == 0 && m_state != 0) begin
            m_sub = 0; m_odo = 0;
        end else if (m_state == 4 && tk) begin
            m_sub++;
            if (m_sub == ODO_T) begin
                m_sub = 0;
                if (m_odo < ODO_MAX) m_odo++;
            end
        end

        if (m_state != 4) begin
            m_phase = 1'b1; m_fcnt = 0;
        end else if (s.tl || s.tr) begin
            if ((s.tl && !m_prev_l) || (s.tr && !m_prev_r)) begin m_phase = 1'b1; m_fcnt = 0; end
            if (tk) begin
                m_fcnt++;
                if (m_fcnt == HALF) begin m_phase = !m_phase; m_fcnt = 0; end
            end
        end else m_fcnt = 0;

        m_cmd = (m_state == 4) ? ((int'(s.dst) << 5) | (int'(s.plc) << 4) | (int'(s.tr) << 3) |
                                  (int'(s.tl) << 2) | (int'(s.rev) << 1) | int'(!s.rev)) : 0;
        m_prev_rev = s.rev; m_prev_l = s.tl; m_prev_r = s.tr;
        m_state = nxt;
        m_ncyc++;
    endtask

    task automatic step(input stim_t s);
        @(negedge sys_clk);
        rst                    = rst_v;
        power_on_signal        = s.pon;
        power_off_signal       = s.poff;
        manual_driving_signal  = s.man;
        throttle_signal        = s.thr;
        clutch_signal          = s.clu;
        brake_signal           = s.brk;
        reverse_signal         = s.rev;
        turn_left_signal       = s.tl;
        turn_right_signal      = s.tr;
        place_barrier_signal   = s.plc;
        destroy_barrier_signal = s.dst;
        model_cycle(s, rst_v);
    endtask

    function automatic stim_t mk(input bit pon, input bit man, input bit thr, input bit clu,
                                 input bit brk, input bit rev);
        stim_t s;
        s = '0;
        s.pon = pon; s.man = man; s.thr = thr; s.clu = clu; s.brk = brk; s.rev = rev;
        return s;
    endfunction

    // From POWER_OFF with idle inputs: the step after this task sees MOVING
    task automatic go_moving();
        for (int i = 0; i < HOLD; i++) step(mk(1, 0, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0));
        step(mk(0, 1, 1, 1, 0, 0));
        step(mk(0, 1, 1, 0, 0, 0));
    endtask

    // Monitor: compare every queued expectation against the DUT
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_state_led", int'(state_led), int'(e.st));
                check("sb_cmd", int'(cmd), int'(e.cmd));
                check("sb_left_led", int'(left_turn_led), int'(e.l));
                check("sb_right_led", int'(right_turn_led), int'(e.r));
                check("sb_reverse_led", int'(reverse_led), int'(e.rv));
                check("sb_odometer", int'(odometer), int'(e.odo));
                check("sb_tick", int'(tick), int'(e.tk));
            end
        end
    end

    initial begin
        stim_t s;
        int    flash_pat [6];
        bit    rv, tl, tr;
        flash_pat = '{1, 1, 0, 0, 1, 1};
        rst = 1'b0; rst_v = 1'b0;
        {power_on_signal, power_off_signal, manual_driving_signal, throttle_signal,
         clutch_signal, brake_signal, reverse_signal, turn_left_signal,
         turn_right_signal, place_barrier_signal, destroy_barrier_signal} = '0;

        step('0); step('0);
        #4; check("reset_state", int'(state_led), 0);
        check("reset_cmd", int'(cmd), 0);
        rst_v = 1'b1;
        step('0); step('0);

        // Power-on hold: too short, then long enough
        for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 0, 0, 0));
        step('0);
        #4; check("short_hold_off", int'(state_led), 0);
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 0, 0));
        step('0);
        #4; check("hold_power_on", int'(state_led), 1);

        // Start and drive
        step(mk(0, 1, 0, 0, 0, 0));
        step(mk(0, 1, 1, 1, 0, 0));
        step(mk(0, 1, 1, 0, 0, 0));
        #4; check("starting", int'(state_led), 3);
        step(mk(0, 1, 1, 0, 0, 0));
        #4; check("moving", int'(state_led), 4);
        step(mk(0, 1, 1, 0, 0, 0));
        #4; check("cmd_forward", int'(cmd), 6'b000001);
        step(mk(0, 1, 1, 1, 0, 1));
        step(mk(0, 1, 1, 0, 0, 1));
        #4; check("cmd_backward", int'(cmd), 6'b000010);
        check("reverse_led", int'(reverse_led), 1);
        step(mk(0, 1, 1, 0, 0, 1));
        step(mk(0, 1, 1, 0, 0, 1));

        // Illegal gear change without clutch
        step(mk(0, 1, 1, 0, 0, 0));
        step('0);
        #4; check("gear_fault_off", int'(state_led), 0);
        step('0);
        #4; check("gear_fault_cmd", int'(cmd), 0);

        // Flash pattern and odometer saturation
        go_moving();
        for (int i = 0; i < 26; i++) begin
            s = mk(0, 1, 1, 0, 0, 0);
            s.tl = 1'b1;
            step(s);
            #4;
            if (i < 6) check("flash_left", int'(left_turn_led), flash_pat[i]);
            if (i == 21 || i == 25) check("odo_saturate", int'(odometer), ODO_MAX);
        end
        s = '0; s.poff = 1'b1;
        step(s);
        step('0);

        // Idle timeout in NOT_STARTING
        for (int i = 0; i < HOLD; i++) step(mk(1, 0, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0));
        for (int i = 0; i <= IDLE; i++) begin
            step('0);
            #4;
            if (i == IDLE - 1) check("idle_last", int'(state_led), 2);
            if (i == IDLE)     check("idle_off", int'(state_led), 0);
        end

        // Stall clears the odometer
        go_moving();
        for (int i = 0; i < 7; i++) step(mk(0, 1, 1, 0, 0, 0));
        step(mk(0, 1, 0, 0, 1, 0));
        #4; check("odo_before_stall", int'(odometer), 2);
        step(mk(0, 1, 1, 0, 0, 0));
        #4; check("stall_not_starting", int'(state_led), 2);
        step('0);
        #4; check("stall_off", int'(state_led), 0);
        check("stall_odo_clear", int'(odometer), 0);

        // Asynchronous reset mid-MOVING
        go_moving();
        for (int i = 0; i < 4; i++) begin
            s = mk(0, 1, 1, 0, 0, 0);
            s.plc = 1'b1;
            step(s);
        end
        @(posedge sys_clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_cmd", int'(cmd), 0);
        check("async_state", int'(state_led), 0);
        check("async_odo", int'(odometer), 0);
        check("async_tick", int'(tick), 0);
        rst_v = 1'b0;
        step('0); step('0);
        rst_v = 1'b1;

        // Randomized traffic against the model
        rv = 1'b0; tl = 1'b0; tr = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) rv = ~rv;
            if ($urandom_range(0, 5) == 0)  tl = ~tl;
            if ($urandom_range(0, 5) == 0)  tr = ~tr;
            s      = '0;
            s.pon  = ($urandom_range(0, 5) != 0);
            s.poff = ($urandom_range(0, 60) == 0);
            s.man  = ($urandom_range(0, 3) != 0);
            s.thr  = ($urandom_range(0, 3) != 0);
            s.clu  = 1'($urandom_range(0, 1));
            s.brk  = ($urandom_range(0, 5) == 0);
            s.rev  = rv;
            s.tl   = tl && ($urandom_range(0, 7) != 0);
            s.tr   = tr;
            s.plc  = 1'($urandom_range(0, 1));
            s.dst  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) s.man = 1'b0;
            step(s);
        end

        step('0);
        @(negedge sys_clk);
        #4;
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
